// File: rtl/merge_unit_p.sv
// Merge-tree node that merges two sorted streams of P-element words into one sorted stream.
// Optional MERGE_UNIT_RUN_COUNT_EN adds o_run_count, which counts terminator words written to the output FIFO.
module merge_unit_p #(
  parameter int DATA_WIDTH = 80,
  parameter int KEY_WIDTH  = 32,
  parameter int P          = 16,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P*DATA_WIDTH-1:0] i_fifo_1,
  input  logic                    i_fifo_1_empty,
  output logic                    o_fifo_1_read,
  input  logic [P*DATA_WIDTH-1:0] i_fifo_2,
  input  logic                    i_fifo_2_empty,
  output logic                    o_fifo_2_read,
  input  logic                    i_fifo_out_ready,
  output logic                    o_out_fifo_write,
`ifdef MERGE_UNIT_RUN_COUNT_EN
  output logic [31:0]             o_run_count,
`endif
  output logic [P*DATA_WIDTH-1:0] o_data
);

  localparam int WW    = P * DATA_WIDTH;
  localparam int LOG_P = $clog2(P);
  localparam int AW    = $clog2(IN_DEPTH);
  localparam int CW    = $clog2(OUT_DEPTH);
  localparam int CNTW  = $clog2(OUT_DEPTH + 1);

  localparam logic [2:0] ST_START   = 3'd0;
  localparam logic [2:0] ST_MERGE   = 3'd1;
  localparam logic [2:0] ST_DRAIN_A = 3'd2;
  localparam logic [2:0] ST_DRAIN_B = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_TERM    = 3'd5;

  // One column of a bitonic merger; equal keys never swap, so ties keep their order.
  function automatic logic [WW-1:0] cmpStage(input logic [WW-1:0] w, input int stride);
    logic [WW-1:0]         r;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;
    r = w;
    for (int i = 0; i < P; i++) begin
      if ((i & stride) == 0) begin
        lo = w[i*DATA_WIDTH +: DATA_WIDTH];
        hi = w[(i+stride)*DATA_WIDTH +: DATA_WIDTH];
        if (hi[KEY_WIDTH-1:0] < lo[KEY_WIDTH-1:0]) begin
          r[i*DATA_WIDTH +: DATA_WIDTH]          = hi;
          r[(i+stride)*DATA_WIDTH +: DATA_WIDTH] = lo;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] bitonicSort(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = w;
    for (int k = 1; k <= LOG_P; k++) begin
      r = cmpStage(r, P >> k);
    end
    return r;
  endfunction

  logic [WW-1:0]   r_memA [IN_DEPTH];
  logic [WW-1:0]   r_memB [IN_DEPTH];
  logic [AW:0]     r_aWr, r_aRd, r_bWr, r_bRd;
  logic [WW-1:0]   r_memC [OUT_DEPTH];
  logic [CW-1:0]   r_cWr, r_cRd;
  logic [CNTW-1:0] r_cCount;
  logic [2:0]      r_state;
  logic [WW-1:0]   r_top;
  logic            r_live;
  logic [LOG_P:0]  r_pipeValid;
  logic [WW-1:0]   r_pipeData [LOG_P+1];

  logic          w_aEmpty, w_aFull, w_bEmpty, w_bFull;
  logic [WW-1:0] w_headA, w_headB, w_selWord, w_mergeIn;
  logic          w_aTerm, w_bTerm, w_selA;
  logic [WW-1:0] w_loRaw, w_hiRaw, w_hiSorted;
  logic          w_popA, w_popB, w_issue, w_credit;
  logic [WW-1:0] w_issueWord, w_topNext;
  logic [2:0]    w_stateNext;
  logic          w_cWrite, w_cRead;
  int            w_used;

  assign w_aEmpty = (r_aWr == r_aRd);
  assign w_bEmpty = (r_bWr == r_bRd);
  assign w_aFull  = (r_aWr[AW] != r_aRd[AW]) && (r_aWr[AW-1:0] == r_aRd[AW-1:0]);
  assign w_bFull  = (r_bWr[AW] != r_bRd[AW]) && (r_bWr[AW-1:0] == r_bRd[AW-1:0]);
  assign w_headA  = r_memA[r_aRd[AW-1:0]];
  assign w_headB  = r_memB[r_bRd[AW-1:0]];

  assign o_fifo_1_read = r_live & ~i_fifo_1_empty & ~w_aFull;
  assign o_fifo_2_read = r_live & ~i_fifo_2_empty & ~w_bFull;

  assign w_aTerm   = (w_headA[KEY_WIDTH-1:0] == '0);
  assign w_bTerm   = (w_headB[KEY_WIDTH-1:0] == '0);
  assign w_selA    = (w_headA[KEY_WIDTH-1:0] <= w_headB[KEY_WIDTH-1:0]);
  assign w_selWord = w_selA ? w_headA : w_headB;

  // Words already in flight have a reserved slot in C, so the pipeline never has to stall.
  assign w_used   = int'(r_cCount) + $countones(r_pipeValid);
  assign w_credit = (w_used < OUT_DEPTH);

  assign w_cWrite         = r_pipeValid[LOG_P];
  assign o_out_fifo_write = i_fifo_out_ready & (r_cCount != '0);
  assign w_cRead          = o_out_fifo_write;
  assign o_data           = r_memC[r_cRd];

  // Half-cleaner of the 2P merge: top ascending followed by the new word reversed is bitonic.
  always_comb begin
    logic [DATA_WIDTH-1:0] elTop;
    logic [DATA_WIDTH-1:0] elNew;
    w_mergeIn = w_selWord;
    case (r_state)
      ST_DRAIN_A: w_mergeIn = w_headA;
      ST_DRAIN_B: w_mergeIn = w_headB;
      default:    w_mergeIn = w_selWord;
    endcase
    w_loRaw = '0;
    w_hiRaw = '0;
    for (int i = 0; i < P; i++) begin
      elTop = r_top[i*DATA_WIDTH +: DATA_WIDTH];
      elNew = w_mergeIn[(P-1-i)*DATA_WIDTH +: DATA_WIDTH];
      if (elTop[KEY_WIDTH-1:0] <= elNew[KEY_WIDTH-1:0]) begin
        w_loRaw[i*DATA_WIDTH +: DATA_WIDTH] = elTop;
        w_hiRaw[i*DATA_WIDTH +: DATA_WIDTH] = elNew;
      end else begin
        w_loRaw[i*DATA_WIDTH +: DATA_WIDTH] = elNew;
        w_hiRaw[i*DATA_WIDTH +: DATA_WIDTH] = elTop;
      end
    end
  end

  assign w_hiSorted = bitonicSort(w_hiRaw);

  always_comb begin
    w_popA      = 1'b0;
    w_popB      = 1'b0;
    w_issue     = 1'b0;
    w_issueWord = w_loRaw;
    w_topNext   = r_top;
    w_stateNext = r_state;
    case (r_state)
      ST_START: begin
        if (!w_aEmpty && !w_bEmpty) begin
          if (w_aTerm && w_bTerm) begin
            w_stateNext = ST_TERM;
          end else if (w_aTerm) begin
            w_popB      = 1'b1;
            w_topNext   = w_headB;
            w_stateNext = ST_DRAIN_B;
          end else if (w_bTerm) begin
            w_popA      = 1'b1;
            w_topNext   = w_headA;
            w_stateNext = ST_DRAIN_A;
          end else begin
            w_popA      = w_selA;
            w_popB      = ~w_selA;
            w_topNext   = w_selWord;
            w_stateNext = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        if (!w_aEmpty && !w_bEmpty) begin
          if (w_aTerm) begin
            w_stateNext = ST_DRAIN_B;
          end else if (w_bTerm) begin
            w_stateNext = ST_DRAIN_A;
          end else if (w_credit) begin
            w_popA    = w_selA;
            w_popB    = ~w_selA;
            w_issue   = 1'b1;
            w_topNext = w_hiSorted;
          end
        end
      end
      ST_DRAIN_A: begin
        if (!w_aEmpty) begin
          if (w_aTerm) begin
            w_stateNext = ST_FLUSH;
          end else if (w_credit) begin
            w_popA    = 1'b1;
            w_issue   = 1'b1;
            w_topNext = w_hiSorted;
          end
        end
      end
      ST_DRAIN_B: begin
        if (!w_bEmpty) begin
          if (w_bTerm) begin
            w_stateNext = ST_FLUSH;
          end else if (w_credit) begin
            w_popB    = 1'b1;
            w_issue   = 1'b1;
            w_topNext = w_hiSorted;
          end
        end
      end
      ST_FLUSH: begin
        if (w_credit) begin
          w_issue     = 1'b1;
          w_issueWord = r_top;
          w_stateNext = ST_TERM;
        end
      end
      ST_TERM: begin
        if (!w_aEmpty && !w_bEmpty && w_credit) begin
          w_issue     = 1'b1;
          w_issueWord = '0;
          w_popA      = 1'b1;
          w_popB      = 1'b1;
          w_topNext   = '0;
          w_stateNext = ST_START;
        end
      end
      default: w_stateNext = ST_START;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_START;
      r_top       <= '0;
      r_live      <= 1'b0;
      r_pipeValid <= '0;
      r_aWr       <= '0;
      r_aRd       <= '0;
      r_bWr       <= '0;
      r_bRd       <= '0;
      r_cWr       <= '0;
      r_cRd       <= '0;
      r_cCount    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_top       <= w_topNext;
      r_live      <= 1'b1;
      r_pipeValid <= {r_pipeValid[LOG_P-1:0], w_issue};
      if (o_fifo_1_read) r_aWr <= r_aWr + 1'b1;
      if (w_popA)        r_aRd <= r_aRd + 1'b1;
      if (o_fifo_2_read) r_bWr <= r_bWr + 1'b1;
      if (w_popB)        r_bRd <= r_bRd + 1'b1;
      if (w_cWrite) r_cWr <= (r_cWr == CW'(OUT_DEPTH-1)) ? '0 : r_cWr + 1'b1;
      if (w_cRead)  r_cRd <= (r_cRd == CW'(OUT_DEPTH-1)) ? '0 : r_cRd + 1'b1;
      r_cCount <= r_cCount + CNTW'(w_cWrite) - CNTW'(w_cRead);
    end
  end

  // Storage arrays carry no reset; the pointers and valid bits above define what is live.
  always_ff @(posedge i_clk) begin
    if (o_fifo_1_read) r_memA[r_aWr[AW-1:0]] <= i_fifo_1;
    if (o_fifo_2_read) r_memB[r_bWr[AW-1:0]] <= i_fifo_2;
    if (w_cWrite)      r_memC[r_cWr] <= r_pipeData[LOG_P];
    r_pipeData[0] <= w_issueWord;
    for (int k = 1; k <= LOG_P; k++) begin
      r_pipeData[k] <= cmpStage(r_pipeData[k-1], P >> k);
    end
  end

`ifdef MERGE_UNIT_RUN_COUNT_EN
  logic [LOG_P:0] r_pipeTerm;
  logic [31:0]    r_runCount;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pipeTerm <= '0;
      r_runCount <= '0;
    end else begin
      r_pipeTerm <= {r_pipeTerm[LOG_P-1:0], w_issue && (r_state == ST_TERM)};
      if (w_cWrite && r_pipeTerm[LOG_P]) r_runCount <= r_runCount + 32'd1;
    end
  end

  assign o_run_count = r_runCount;
`endif

endmodule

// File: tb/tb_merge_unit_p.sv
// Scoreboard bench for merge_unit_p at P=4: directed runs, ties, backpressure and mid-run reset.
module tb_merge_unit_p;

  localparam int WW = 128;

  logic          i_clk;
  logic          i_rst_n;
  logic [WW-1:0] i_fifo_1;
  logic          i_fifo_1_empty;
  logic          o_fifo_1_read;
  logic [WW-1:0] i_fifo_2;
  logic          i_fifo_2_empty;
  logic          o_fifo_2_read;
  logic          i_fifo_out_ready;
  logic          o_out_fifo_write;
  logic [WW-1:0] o_data;
`ifdef MERGE_UNIT_RUN_COUNT_EN
  logic [31:0]   o_run_count;
`endif

  merge_unit_p #(
    .DATA_WIDTH(32), .KEY_WIDTH(16), .P(4), .IN_DEPTH(4), .OUT_DEPTH(8)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_fifo_1(i_fifo_1),
    .i_fifo_1_empty(i_fifo_1_empty),
    .o_fifo_1_read(o_fifo_1_read),
    .i_fifo_2(i_fifo_2),
    .i_fifo_2_empty(i_fifo_2_empty),
    .o_fifo_2_read(o_fifo_2_read),
    .i_fifo_out_ready(i_fifo_out_ready),
    .o_out_fifo_write(o_out_fifo_write),
`ifdef MERGE_UNIT_RUN_COUNT_EN
    .o_run_count(o_run_count),
`endif
    .o_data(o_data)
  );

  logic [WW-1:0] qA[$];
  logic [WW-1:0] qB[$];
  logic [WW-1:0] expQ[$];
  int checks;
  int failures;
  int expRuns;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [WW-1:0] mkWord(input int k0, input int k1, input int k2,
                                           input int k3, input logic [15:0] px);
    logic [15:0] e0, e1, e2, e3;
    e0 = 16'(k0);
    e1 = 16'(k1);
    e2 = 16'(k2);
    e3 = 16'(k3);
    return {e3 ^ px, e3, e2 ^ px, e2, e1 ^ px, e1, e0 ^ px, e0};
  endfunction

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Upstream FWFT model: the read strobe is sampled at negedge and the pop applied after the edge.
  initial begin
    logic rdA;
    logic rdB;
    i_fifo_1 = '0;
    i_fifo_2 = '0;
    i_fifo_1_empty = 1'b1;
    i_fifo_2_empty = 1'b1;
    forever begin
      @(negedge i_clk);
      rdA = o_fifo_1_read;
      rdB = o_fifo_2_read;
      @(posedge i_clk);
      #1;
      if (i_rst_n && rdA && qA.size() > 0) void'(qA.pop_front());
      if (i_rst_n && rdB && qB.size() > 0) void'(qB.pop_front());
      i_fifo_1       = (qA.size() > 0) ? qA[0] : '0;
      i_fifo_1_empty = (qA.size() == 0);
      i_fifo_2       = (qB.size() > 0) ? qB[0] : '0;
      i_fifo_2_empty = (qB.size() == 0);
    end
  end

  // Monitor: every written output word is matched against the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n && o_out_fifo_write) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output got=%h required=none", o_data);
      end else begin
        checkOutput("out_word", o_data, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int testId);
    logic [15:0] px;
    px = 16'h5A00;
    case (testId)
      1: begin
        qA.push_back(mkWord(1, 3, 5, 7, px));
        qA.push_back(mkWord(9, 11, 13, 15, px));
        qA.push_back('0);
        qB.push_back(mkWord(2, 4, 6, 8, px));
        qB.push_back(mkWord(10, 12, 14, 16, px));
        qB.push_back('0);
        expQ.push_back(mkWord(1, 2, 3, 4, px));
        expQ.push_back(mkWord(5, 6, 7, 8, px));
        expQ.push_back(mkWord(9, 10, 11, 12, px));
        expQ.push_back(mkWord(13, 14, 15, 16, px));
      end
      2: begin
        qA.push_back('0);
        qB.push_back('0);
      end
      3: begin
        qA.push_back('0);
        qB.push_back(mkWord(2, 4, 6, 8, px));
        qB.push_back(mkWord(10, 12, 14, 16, px));
        qB.push_back('0);
        expQ.push_back(mkWord(2, 4, 6, 8, px));
        expQ.push_back(mkWord(10, 12, 14, 16, px));
      end
      4: begin
        qA.push_back(mkWord(5, 5, 5, 5, 16'hA000));
        qA.push_back('0);
        qB.push_back(mkWord(5, 5, 5, 5, 16'hB000));
        qB.push_back('0);
        expQ.push_back(mkWord(5, 5, 5, 5, 16'hA000));
        expQ.push_back(mkWord(5, 5, 5, 5, 16'hB000));
      end
      default: begin
        for (int w = 0; w < 10; w++) begin
          qA.push_back(mkWord(8*w+1, 8*w+3, 8*w+5, 8*w+7, px));
          qB.push_back(mkWord(8*w+2, 8*w+4, 8*w+6, 8*w+8, px));
        end
        qA.push_back('0);
        qB.push_back('0);
        for (int w = 0; w < 20; w++) begin
          expQ.push_back(mkWord(4*w+1, 4*w+2, 4*w+3, 4*w+4, px));
        end
      end
    endcase
    expQ.push_back('0);
    expRuns++;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || qA.size() != 0 || qB.size() != 0) && n < 1000) begin
      @(posedge i_clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("[TB] FAIL %s_timeout got=%0d_words_pending required=0", name, expQ.size());
    end
    repeat (10) @(posedge i_clk);
`ifdef MERGE_UNIT_RUN_COUNT_EN
    checkOutput({name, "_run_count"}, WW'(o_run_count), WW'(expRuns));
`endif
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    expRuns = 0;
    i_rst_n = 1'b0;
    i_fifo_out_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    checkOutput("reset_write", WW'(o_out_fifo_write), '0);
    checkOutput("reset_read1", WW'(o_fifo_1_read), '0);
    checkOutput("reset_read2", WW'(o_fifo_2_read), '0);

    $display("[TB] two-run merge");
    applyStimulus(1);
    waitDrain("merge4");
    $display("[TB] empty run");
    applyStimulus(2);
    waitDrain("empty_run");
    $display("[TB] one-sided run");
    applyStimulus(3);
    waitDrain("one_sided");
    $display("[TB] tie ordering");
    applyStimulus(4);
    waitDrain("ties");

    $display("[TB] backpressure");
    applyStimulus(5);
    n = 0;
    while (expQ.size() > 20 && n < 100) begin
      @(posedge i_clk);
      #3;
      n++;
    end
    i_fifo_out_ready = 1'b0;
    checks++;
    if (n >= 100) begin
      failures++;
      $display("[TB] FAIL stall_start_timeout got=%0d required=20", expQ.size());
    end
    repeat (40) @(posedge i_clk);
    #3;
    checkOutput("stall_read1", WW'(o_fifo_1_read), '0);
    checkOutput("stall_read2", WW'(o_fifo_2_read), '0);
    checkOutput("stall_up1_empty", WW'(i_fifo_1_empty), '0);
    checkOutput("stall_up2_empty", WW'(i_fifo_2_empty), '0);
    i_fifo_out_ready = 1'b1;
    waitDrain("backpressure");

    $display("[TB] reset mid-run");
    applyStimulus(1);
    repeat (4) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    qA.delete();
    qB.delete();
    expQ.delete();
    expRuns = 0;
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    checkOutput("midreset_write", WW'(o_out_fifo_write), '0);
    checkOutput("midreset_read1", WW'(o_fifo_1_read), '0);
    checkOutput("midreset_read2", WW'(o_fifo_2_read), '0);
    applyStimulus(1);
    waitDrain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merge_unit_p.md
Name: merge_unit_p

Overview:
- Parametrised successor to the fixed 16-wide merger: merges two sorted streams of P-element words into one sorted stream of P-element words.
- Sustains one output word per cycle.
- Understands run terminators (key 0), so back-to-back runs flow through without software intervention.
- Sits between two upstream first-word-fall-through (FWFT) FIFOs and one downstream FIFO at every node of the merge tree.
- New relative to the 16-wide block: P, KEY_WIDTH and depths are parametric; synchronous reset; credit-based issue (the pipeline never stalls); explicit end-of-run flush.

Parameters:
- DATA_WIDTH, 80, bits per element.
- KEY_WIDTH, 32, sort key = element[KEY_WIDTH-1:0]. Key 0 is the terminator.
- P, 16, elements per word. Power of two, 2..32.
- IN_DEPTH, 16, depth of internal input FIFOs A and B. Power of two, ≥2.
- OUT_DEPTH, 16, depth of output FIFO C. Must be ≥ log2(P)+4.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_fifo_1  in  P*DATA_WIDTH  head word of stream A. Element 0 in the LSBs. Elements ascending within the word.
- i_fifo_1_empty  in  1  stream A upstream empty.
- o_fifo_1_read  out  1  pops upstream A (FWFT; data is taken this cycle).
- i_fifo_2  in  P*DATA_WIDTH  head word of stream B.
- i_fifo_2_empty  in  1  stream B upstream empty.
- o_fifo_2_read  out  1  pops upstream B.
- i_fifo_out_ready  in  1  downstream can accept a word this cycle.
- o_out_fifo_write  out  1  o_data is valid and written downstream this cycle.
- o_data  out  P*DATA_WIDTH  merged output word.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - Clears FIFOs A/B/C, pipeline valid bits and the top register.
  - State goes to START.
  - o_fifo_1_read, o_fifo_2_read and o_out_fifo_write are 0 from the first cycle after reset.
  - Reset applied mid-run discards all in-flight words.
- Input side:
  - o_fifo_1_read = ~i_fifo_1_empty & ~A_full; same rule for B.
  - A and B are FWFT internally.
- Output side:
  - o_out_fifo_write = i_fifo_out_ready & ~C_empty, combinational.
  - o_data = head of C.
- Issue credit:
  - A word may be issued into the pipeline only when C_count + words_in_flight < OUT_DEPTH.
  - With credit, C never overflows and the pipeline never stalls.
- Selection: compare head keys, element 0 of A against element 0 of B. The smaller key is selected; on a tie, A is selected.
- States:
  - START: the first selected non-terminator word loads top directly, with no output; go to MERGE.
    - Both heads are terminators: go to TERM.
    - One head is a terminator: go to DRAIN of the other stream, still loading top first.
  - MERGE: needs both heads present.
    - A head is a terminator: go to DRAIN_B. B head is a terminator: go to DRAIN_A.
    - Otherwise pop the selected word W and merge W with top through a 2P bitonic merge.
    - The lower P elements are issued to the pipeline.
    - The upper P elements, fully sorted, become top in the same cycle. This feedback path is single-cycle combinational.
  - DRAIN_A / DRAIN_B: merge the remaining words of one stream with top, as in MERGE. On that stream's terminator, go to FLUSH.
  - FLUSH: issue top as a word (needs 1 credit); go to TERM.
  - TERM:
    - Issue an all-zero terminator word (needs 1 credit).
    - Pop the terminator word from both A and B in the same cycle.
    - Clear top; go to START.
    - Terminators are never merged with data.
- Lower-half pipeline:
  - Registered at issue, then log2(P) compare stages.
  - Word written to C at issue_cycle + log2(P) + 1.
  - Visible on o_data one cycle later if C was empty.
- Any state with a required head missing, or no credit, issues nothing that cycle (bubble). No data corruption.
- Input contract: runs are whole words; non-terminator keys are nonzero; each run is ascending across words. Behaviour for violating input is undefined but must not hang the block.

Optional Feature:
- Macro MERGE_UNIT_RUN_COUNT_EN.
- Defined:
  - Adds port o_run_count, out, 32 bits.
  - Increments on each terminator word written to C; wraps modulo 2^32.
  - Cleared by reset.
- Undefined: the port and counter are absent. Merge behaviour is identical.

Test Plan:
- P=4 merge: A=[1,3,5,7],[9,11,13,15],[0]; B=[2,4,6,8],[10,12,14,16],[0] → output [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16],[0,0,0,0]; o_run_count=1.
- Empty run: A=[0], B=[0] → exactly one zero word; both upstream terminators popped.
- One-sided run: A=[0], B=[2,4,6,8],[10,12,14,16],[0] → B words unchanged, then zero word; A terminator popped only at TERM.
- Ties: A=[5,5,5,5],[0], B=[5,5,5,5],[0] → [5,5,5,5] twice, then zero. A's word is issued first (check payload bits).
- Backpressure: hold i_fifo_out_ready=0 for 40 cycles mid-run → no C overflow, o_fifo_x_read drops when A/B are full, output after release is identical to the unstalled golden output.
- Reset mid-run: pulse i_rst_n=0 for 1 cycle during MERGE → outputs 0 next cycle; the following fresh run (case 1 stimulus) is reproduced exactly.
